trace_capture: RTL and testbench
================================

Name: trace_capture

Overview:
- Synthesizable successor to the processor bench's free-running cycle monitor.
- Captures per-cycle CPU retire/writeback samples (PC, instruction, write register, write data, cycle stamp) into a circular buffer.
- Freezes the buffer a programmable number of samples after a PC-match or forced trigger, then drains it through a valid/ready port.
- Sits beside the processor core; taps retire signals only and never stalls the core.

Parameters:
- DATA_W, 16, width of PC, instruction and write-data fields
- REG_W, 3, width of the write-register index
- TS_W, 16, width of the cycle stamp
- DEPTH, 16, buffer entries; power of two, >= 2
- POST_TRIG, 8, samples stored after the trigger sample; must be < DEPTH

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = in reset)
- arm  in  1  start capture; honoured only in IDLE
- abort  in  1  return to IDLE from any state; clears buffer
- trig_en  in  1  enable PC-match trigger
- trig_pc  in  DATA_W  PC value that fires the trigger
- force_trig  in  1  immediate trigger while ARMED
- cap_valid  in  1  retire sample valid this cycle
- cap_pc  in  DATA_W  retired PC
- cap_instr  in  DATA_W  retired instruction
- cap_wen  in  1  register write occurred
- cap_wreg  in  REG_W  written register index
- cap_wdata  in  DATA_W  written data
- rd_valid  out  1  buffered entry available
- rd_ready  in  1  consumer accepts entry
- rd_pc, rd_instr, rd_wdata  out  DATA_W  entry fields
- rd_wreg  out  REG_W  entry field
- rd_wen  out  1  entry field
- rd_ts  out  TS_W  entry cycle stamp
- busy  out  1  state is ARMED or POST
- triggered  out  1  sticky; set on trigger, cleared on entry to IDLE
- fill  out  $clog2(DEPTH)+1  valid entries held

Behaviour:
- Reset:
  - state = IDLE
  - wr_ptr, rd_ptr, fill, post_cnt, ts = 0
  - rd_valid, busy, triggered = 0
  - Memory contents are don't-care.
- States: IDLE, ARMED, POST, DONE.
- IDLE:
  - cap_valid ignored.
  - arm=1 -> ARMED next cycle; ts, fill, pointers cleared.
  - A trigger condition in the same cycle as arm is not evaluated.
- ARMED:
  - Each cap_valid cycle writes the sample plus ts at wr_ptr; wr_ptr increments mod DEPTH.
  - fill increments and saturates at DEPTH; when full, the oldest entry is overwritten and rd_ptr advances with wr_ptr.
  - Trigger = cap_valid & ((trig_en & cap_pc==trig_pc) | force_trig).
  - On trigger, the triggering sample is stored, triggered is set, post_cnt loads POST_TRIG, and the next state is POST (or DONE if POST_TRIG==0).
  - force_trig without cap_valid is held pending and fires on the next cap_valid.
- POST:
  - Each stored sample decrements post_cnt; the sample that brings it to 0 moves the state to DONE.
  - Overwrite rules as in ARMED.
  - Further trigger conditions are ignored.
- ts increments every cycle in ARMED/POST, saturates at all-ones, and is frozen in DONE.
- DONE:
  - Capture stops.
  - rd_valid = (fill != 0).
  - rd_* fields are combinational from mem[rd_ptr] (zero read latency).
  - rd_valid & rd_ready pops the entry: rd_ptr++, fill--.
  - The pop that empties the buffer moves the state to IDLE next cycle.
  - The rd_* fields hold stable while rd_valid=1 and rd_ready=0.
- abort:
  - Has priority over everything except reset.
  - Next state is IDLE; fill and pointers are cleared; triggered is cleared.
- arm outside IDLE is ignored.
- Entries leave the buffer oldest first; the trigger sample sits at position fill-1-POST_TRIG from the head.
- Asynchronous reset mid-capture or mid-drain: all state is lost; the block returns to reset values immediately.

Decomposition:
- Shared package tc_pkg: state enum (IDLE/ARMED/POST/DONE) and the packed entry struct {pc, instr, wen, wreg, wdata, ts} sized from the parameters.
- One natural sub-module, tc_ring_mem: DEPTH-entry memory with synchronous write and asynchronous read on packed entries.
- The FSM, pointer logic and cycle-stamp counter stay in trace_capture.

Test Plan:
- Reset and idle: reset low 3 cycles then high, cap_valid toggling with no arm -> fill=0, rd_valid=0, busy=0.
- PC-match trigger: DEPTH=16, POST_TRIG=4, arm, then 10 samples with PC 0..9, trig_pc=5 -> DONE, fill=10. Drain yields PC 0..9 in order with ts strictly increasing; the block returns to IDLE after the 10th pop.
- Wrap and overwrite: 40 samples with PC 0..39, trigger at PC 30, POST_TRIG=8 -> 39 samples stored, fill=16. Drain yields PC 23..38.
- Trigger edge cases:
  - force_trig while cap_valid=0 -> fires on the next cap_valid.
  - POST_TRIG=0 -> the trigger sample is the last entry.
  - arm and a matching PC in the same cycle -> no trigger.
- Backpressure and abort:
  - rd_ready low for 5 cycles with rd_valid high -> rd_* fields stable.
  - abort during POST -> IDLE next cycle, fill=0, triggered=0.
- Async reset mid-drain: reset asserted between edges -> rd_valid=0 and busy=0 immediately; arm works normally after release.

Source files
------------

// File: rtl/tc_pkg.sv
// Shared types for the trace capture block: FSM state and the packed
// buffer entry. Field widths here are the defaults of trace_capture.
package tc_pkg;

  localparam int unsigned TC_DATA_W = 16;
  localparam int unsigned TC_REG_W  = 3;
  localparam int unsigned TC_TS_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_POST,
    ST_DONE
  } tc_state_e;

  typedef struct packed {
    logic [TC_DATA_W-1:0] pc;
    logic [TC_DATA_W-1:0] instr;
    logic                 wen;
    logic [TC_REG_W-1:0]  wreg;
    logic [TC_DATA_W-1:0] wdata;
    logic [TC_TS_W-1:0]   ts;
  } tc_entry_t;

endpackage

// File: rtl/tc_ring_mem.sv
// Circular trace storage: synchronous write, zero-latency read so the
// drain port can present the head entry combinationally.
module tc_ring_mem
  import tc_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  tc_entry_t     i_wdata,
  input  logic [AW-1:0] i_raddr,
  output tc_entry_t     o_rdata
);

  tc_entry_t r_mem [DEPTH];

  // Sample write; contents need no reset since fill gates every read.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/trace_capture.sv
// Retire-trace capture: records samples into a ring while armed, freezes
// POST_TRIG samples after a trigger, then drains oldest-first over a
// valid/ready port. Never back-pressures the core.
module trace_capture
  import tc_pkg::*;
#(
  parameter int unsigned DATA_W    = TC_DATA_W,
  parameter int unsigned REG_W     = TC_REG_W,
  parameter int unsigned TS_W      = TC_TS_W,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned POST_TRIG = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   arm,
  input  logic                   abort,
  input  logic                   trig_en,
  input  logic [DATA_W-1:0]      trig_pc,
  input  logic                   force_trig,
  input  logic                   cap_valid,
  input  logic [DATA_W-1:0]      cap_pc,
  input  logic [DATA_W-1:0]      cap_instr,
  input  logic                   cap_wen,
  input  logic [REG_W-1:0]       cap_wreg,
  input  logic [DATA_W-1:0]      cap_wdata,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [DATA_W-1:0]      rd_pc,
  output logic [DATA_W-1:0]      rd_instr,
  output logic [DATA_W-1:0]      rd_wdata,
  output logic [REG_W-1:0]       rd_wreg,
  output logic                   rd_wen,
  output logic [TS_W-1:0]        rd_ts,
  output logic                   busy,
  output logic                   triggered,
  output logic [$clog2(DEPTH):0] fill
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned FW = AW + 1;

  tc_state_e       r_state;
  tc_state_e       w_state_nxt;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_post_cnt;
  logic [FW-1:0]   r_fill;
  logic [TS_W-1:0] r_ts;
  logic            r_triggered;
  logic            r_pend;

  logic            w_armed;
  logic            w_post;
  logic            w_done;
  logic            w_store;
  logic            w_trig;
  logic            w_full;
  logic            w_rd_valid;
  logic            w_pop;
  tc_entry_t       w_wr_entry;
  tc_entry_t       w_rd_entry;

  assign w_armed    = (r_state == ST_ARMED);
  assign w_post     = (r_state == ST_POST);
  assign w_done     = (r_state == ST_DONE);
  assign w_store    = cap_valid & (w_armed | w_post);
  // A force_trig seen without a sample is remembered in r_pend.
  assign w_trig     = w_armed & cap_valid &
                      (force_trig | r_pend | (trig_en & (cap_pc == trig_pc)));
  assign w_full     = (r_fill == FW'(DEPTH));
  assign w_rd_valid = w_done & (r_fill != '0);
  assign w_pop      = w_rd_valid & rd_ready;

  assign w_wr_entry.pc    = cap_pc;
  assign w_wr_entry.instr = cap_instr;
  assign w_wr_entry.wen   = cap_wen;
  assign w_wr_entry.wreg  = cap_wreg;
  assign w_wr_entry.wdata = cap_wdata;
  assign w_wr_entry.ts    = r_ts;

  tc_ring_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_store & ~abort),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wr_entry),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_entry)
  );

  // Next-state selection; abort overrides every state.
  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE:  if (arm) w_state_nxt = ST_ARMED;
        ST_ARMED: if (w_trig) w_state_nxt = (POST_TRIG == 0) ? ST_DONE : ST_POST;
        ST_POST:  if (cap_valid && (r_post_cnt == AW'(1))) w_state_nxt = ST_DONE;
        ST_DONE:  if (w_pop && (r_fill == FW'(1))) w_state_nxt = ST_IDLE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State, ring pointers, occupancy, post counter and cycle stamp.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_fill      <= '0;
      r_post_cnt  <= '0;
      r_ts        <= '0;
      r_triggered <= 1'b0;
      r_pend      <= 1'b0;
    end else if (abort) begin
      r_state     <= ST_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_fill      <= '0;
      r_post_cnt  <= '0;
      r_triggered <= 1'b0;
      r_pend      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt == ST_IDLE) begin
        r_triggered <= 1'b0;
      end
      unique case (r_state)
        ST_IDLE: begin
          if (arm) begin
            r_ts     <= '0;
            r_fill   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_pend   <= 1'b0;
          end
        end
        ST_ARMED, ST_POST: begin
          if (r_ts != '1) begin
            r_ts <= r_ts + TS_W'(1);
          end
          if (cap_valid) begin
            // A full ring drops its oldest entry as the new one lands.
            r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_full) begin
              r_rd_ptr <= r_rd_ptr + AW'(1);
            end else begin
              r_fill <= r_fill + FW'(1);
            end
          end
          if (w_armed) begin
            if (w_trig) begin
              r_triggered <= 1'b1;
              r_post_cnt  <= AW'(POST_TRIG);
              r_pend      <= 1'b0;
            end else if (force_trig) begin
              r_pend <= 1'b1;
            end
          end else if (cap_valid) begin
            r_post_cnt <= r_post_cnt - AW'(1);
          end
        end
        ST_DONE: begin
          if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
            r_fill   <= r_fill - FW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_valid  = w_rd_valid;
  assign rd_pc     = w_rd_entry.pc;
  assign rd_instr  = w_rd_entry.instr;
  assign rd_wen    = w_rd_entry.wen;
  assign rd_wreg   = w_rd_entry.wreg;
  assign rd_wdata  = w_rd_entry.wdata;
  assign rd_ts     = w_rd_entry.ts;
  assign busy      = w_armed | w_post;
  assign triggered = r_triggered;
  assign fill      = r_fill;

endmodule

// File: tb/tb_trace_capture.sv
// Bench for trace_capture: three instances (POST_TRIG 4, 8, 0) share the
// same stimulus; a queue-based reference model predicts every output.
module tb_trace_capture;

  logic        clk;
  logic        reset;
  logic        arm;
  logic        abort;
  logic        trig_en;
  logic [15:0] trig_pc;
  logic        force_trig;
  logic        cap_valid;
  logic [15:0] cap_pc;
  logic [15:0] cap_instr;
  logic        cap_wen;
  logic [2:0]  cap_wreg;
  logic [15:0] cap_wdata;
  logic        rd_ready;

  logic        o_rv   [3];
  logic [15:0] o_pc   [3];
  logic [15:0] o_ins  [3];
  logic [15:0] o_wd   [3];
  logic [2:0]  o_wr   [3];
  logic        o_we   [3];
  logic [15:0] o_ts   [3];
  logic        o_busy [3];
  logic        o_trg  [3];
  logic [4:0]  o_fill [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    trace_capture #(
      .DATA_W    (16),
      .REG_W     (3),
      .TS_W      (16),
      .DEPTH     (16),
      .POST_TRIG ((g == 0) ? 4 : ((g == 1) ? 8 : 0))
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .arm        (arm),
      .abort      (abort),
      .trig_en    (trig_en),
      .trig_pc    (trig_pc),
      .force_trig (force_trig),
      .cap_valid  (cap_valid),
      .cap_pc     (cap_pc),
      .cap_instr  (cap_instr),
      .cap_wen    (cap_wen),
      .cap_wreg   (cap_wreg),
      .cap_wdata  (cap_wdata),
      .rd_valid   (o_rv[g]),
      .rd_ready   (rd_ready),
      .rd_pc      (o_pc[g]),
      .rd_instr   (o_ins[g]),
      .rd_wdata   (o_wd[g]),
      .rd_wreg    (o_wr[g]),
      .rd_wen     (o_we[g]),
      .rd_ts      (o_ts[g]),
      .busy       (o_busy[g]),
      .triggered  (o_trg[g]),
      .fill       (o_fill[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
    logic        wen;
    logic [2:0]  wreg;
    logic [15:0] wdata;
    logic [15:0] ts;
  } ent_t;

  // Model: phase 0 idle, 1 armed, 2 post, 3 done.
  int   m_phase [3];
  int   m_left  [3];
  int   m_ts    [3];
  bit   m_trig  [3];
  bit   m_pend  [3];
  ent_t m_q     [3][$];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic int pt_of(input int k);
    return (k == 0) ? 4 : ((k == 1) ? 8 : 0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_phase[k] = 0; m_left[k] = 0; m_ts[k] = 0;
      m_trig[k] = 0; m_pend[k] = 0;
      m_q[k].delete();
    end
  endtask

  task automatic model_step();
    ent_t e;
    bit   pop;
    if (!reset) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 3; k++) begin
      pop = (m_phase[k] == 3) && (m_q[k].size() != 0) && rd_ready;
      if (abort) begin
        m_phase[k] = 0; m_trig[k] = 0; m_pend[k] = 0;
        m_q[k].delete();
      end else begin
        case (m_phase[k])
          0: if (arm) begin
            m_phase[k] = 1; m_ts[k] = 0; m_pend[k] = 0;
            m_q[k].delete();
          end
          1, 2: begin
            if (cap_valid) begin
              e = '{pc: cap_pc, instr: cap_instr, wen: cap_wen, wreg: cap_wreg,
                    wdata: cap_wdata, ts: 16'(m_ts[k])};
              m_q[k].push_back(e);
              if (m_q[k].size() > 16) void'(m_q[k].pop_front());
            end
            if (m_phase[k] == 1) begin
              if (cap_valid && (force_trig || m_pend[k] || (trig_en && cap_pc == trig_pc))) begin
                m_trig[k] = 1; m_pend[k] = 0; m_left[k] = pt_of(k);
                m_phase[k] = (pt_of(k) == 0) ? 3 : 2;
              end else if (force_trig) begin
                m_pend[k] = 1;
              end
            end else if (cap_valid) begin
              m_left[k]--;
              if (m_left[k] == 0) m_phase[k] = 3;
            end
            if (m_ts[k] < 65535) m_ts[k]++;
          end
          default: if (pop) begin
            void'(m_q[k].pop_front());
            if (m_q[k].size() == 0) begin
              m_phase[k] = 0; m_trig[k] = 0;
            end
          end
        endcase
      end
    end
  endtask

  task automatic check_all();
    bit ev;
    for (int k = 0; k < 3; k++) begin
      ev = (m_phase[k] == 3) && (m_q[k].size() != 0);
      chk($sformatf("rd_valid[%0d]", k), 32'(o_rv[k]), 32'(ev));
      chk($sformatf("busy[%0d]", k), 32'(o_busy[k]), 32'(m_phase[k] == 1 || m_phase[k] == 2));
      chk($sformatf("triggered[%0d]", k), 32'(o_trg[k]), 32'(m_trig[k]));
      chk($sformatf("fill[%0d]", k), 32'(o_fill[k]), 32'(m_q[k].size()));
      if (ev) begin
        chk($sformatf("rd_pc[%0d]", k),    32'(o_pc[k]),  32'(m_q[k][0].pc));
        chk($sformatf("rd_instr[%0d]", k), 32'(o_ins[k]), 32'(m_q[k][0].instr));
        chk($sformatf("rd_wen[%0d]", k),   32'(o_we[k]),  32'(m_q[k][0].wen));
        chk($sformatf("rd_wreg[%0d]", k),  32'(o_wr[k]),  32'(m_q[k][0].wreg));
        chk($sformatf("rd_wdata[%0d]", k), 32'(o_wd[k]),  32'(m_q[k][0].wdata));
        chk($sformatf("rd_ts[%0d]", k),    32'(o_ts[k]),  32'(m_q[k][0].ts));
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic send(input logic [15:0] pc);
    repeat ($urandom_range(0, 1)) cyc();
    cap_valid = 1'b1;
    cap_pc    = pc;
    cap_instr = 16'($urandom());
    cap_wen   = 1'($urandom());
    cap_wreg  = 3'($urandom());
    cap_wdata = 16'($urandom());
    cyc();
    cap_valid = 1'b0;
  endtask

  task automatic restart();
    abort = 1'b1; cyc(); abort = 1'b0;
    arm = 1'b1;   cyc(); arm = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((m_phase[0] == 3 || m_phase[1] == 3 || m_phase[2] == 3) && n < budget) begin
      rd_ready = ($urandom_range(0, 3) != 0);
      cyc();
      n++;
    end
    rd_ready = 1'b0;
    for (int k = 0; k < 3; k++) chk($sformatf("drained_rv[%0d]", k), 32'(o_rv[k]), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; arm = 1'b0; abort = 1'b0; trig_en = 1'b1; trig_pc = 16'd5;
    force_trig = 1'b0; cap_valid = 1'b0; cap_pc = '0; cap_instr = '0;
    cap_wen = 1'b0; cap_wreg = '0; cap_wdata = '0; rd_ready = 1'b0;
    model_reset();

    // Reset held for 3 cycles, then idle with samples but no arm.
    repeat (3) begin cap_valid = ~cap_valid; cap_pc = 16'd5; cyc(); end
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cap_valid = ~cap_valid; cap_pc = 16'($urandom_range(0, 9)); cyc();
    end
    cap_valid = 1'b0;
    chk("idle_fill", 32'(o_fill[0]), 32'd0);
    chk("idle_busy", 32'(o_busy[0]), 32'd0);

    // PC-match trigger at PC 5, ten samples.
    restart();
    for (int p = 0; p < 10; p++) send(16'(p));
    cyc();
    chk("pcm_fill0", 32'(o_fill[0]), 32'd10);
    chk("pcm_head0", 32'(o_pc[0]), 32'd0);
    chk("pcm_fill2", 32'(o_fill[2]), 32'd6);
    drain(200);
    chk("pcm_idle_busy0", 32'(o_busy[0]), 32'd0);
    chk("pcm_idle_trg0", 32'(o_trg[0]), 32'd0);

    // Wrap and overwrite: 40 samples, trigger at PC 30.
    trig_pc = 16'd30;
    restart();
    for (int p = 0; p < 40; p++) send(16'(p));
    cyc();
    chk("wrap_fill1", 32'(o_fill[1]), 32'd16);
    chk("wrap_head1", 32'(o_pc[1]), 32'd23);
    chk("wrap_head0", 32'(o_pc[0]), 32'd19);
    chk("wrap_head2", 32'(o_pc[2]), 32'd15);
    drain(300);

    // force_trig with no sample is held until the next sample.
    trig_en = 1'b0;
    restart();
    for (int p = 100; p < 103; p++) send(16'(p));
    cyc();
    force_trig = 1'b1; cyc(); force_trig = 1'b0;
    cyc(); cyc();
    chk("force_pending_trg0", 32'(o_trg[0]), 32'd0);
    send(16'd103);
    chk("force_fired_trg0", 32'(o_trg[0]), 32'd1);
    chk("force_pt0_busy2", 32'(o_busy[2]), 32'd0);
    chk("force_pt0_fill2", 32'(o_fill[2]), 32'd4);
    for (int p = 104; p < 112; p++) send(16'(p));
    cyc();
    // Backpressure: hold rd_ready low with entries pending.
    rd_ready = 1'b0;
    repeat (5) cyc();
    chk("bp_head0", 32'(o_pc[0]), 32'd100);
    drain(300);

    // arm together with a matching PC: no trigger, no capture.
    trig_en = 1'b1; trig_pc = 16'd5;
    abort = 1'b1; cyc(); abort = 1'b0;
    arm = 1'b1; cap_valid = 1'b1; cap_pc = 16'd5; cyc();
    arm = 1'b0; cap_valid = 1'b0; cyc();
    chk("armtrig_trg1", 32'(o_trg[1]), 32'd0);
    chk("armtrig_fill1", 32'(o_fill[1]), 32'd0);
    chk("armtrig_busy1", 32'(o_busy[1]), 32'd1);
    send(16'd6);

    // abort while the POST_TRIG=8 instance is in POST.
    restart();
    for (int p = 0; p < 7; p++) send(16'(p));
    chk("abort_pre_busy1", 32'(o_busy[1]), 32'd1);
    abort = 1'b1; cyc(); abort = 1'b0;
    chk("abort_busy1", 32'(o_busy[1]), 32'd0);
    chk("abort_fill1", 32'(o_fill[1]), 32'd0);
    chk("abort_trg1", 32'(o_trg[1]), 32'd0);

    // Asynchronous reset in the middle of a drain.
    restart();
    for (int p = 0; p < 10; p++) send(16'(p));
    rd_ready = 1'b1; cyc(); cyc(); rd_ready = 1'b0;
    #3; reset = 1'b0; #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("areset_rv[%0d]", k), 32'(o_rv[k]), 32'd0);
      chk($sformatf("areset_busy[%0d]", k), 32'(o_busy[k]), 32'd0);
      chk($sformatf("areset_fill[%0d]", k), 32'(o_fill[k]), 32'd0);
    end
    model_reset();
    cyc(); cyc();
    reset = 1'b1;
    arm = 1'b1; cyc(); arm = 1'b0;
    for (int p = 0; p < 10; p++) send(16'(p));
    cyc();
    chk("post_reset_fill0", 32'(o_fill[0]), 32'd10);
    drain(200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
